// File: rtl/wash_timer_if.sv
// wash_timer_if -- command/preset/status bundle for the wash countdown timer.
//   tick_in     : divided 1 Hz square wave, asynchronous to clk
//   load        : capture preset_min / preset_sec
//   preset_min  : minute preset (7 bit)
//   preset_sec  : second preset (6 bit)
//   start/pause : begin/resume and suspend the countdown
//   min_out     : remaining minutes (registered)
//   sec_out     : remaining seconds 0..59 (registered)
//   running     : high while counting down
//   done        : one-clk pulse on expiry
// slave = timer side, master = controller/bench side.
interface wash_timer_if;
    logic       tick_in;
    logic       load;
    logic [6:0] preset_min;
    logic [5:0] preset_sec;
    logic       start;
    logic       pause;
    logic [6:0] min_out;
    logic [5:0] sec_out;
    logic       running;
    logic       done;

    modport slave (
        input  tick_in, load, preset_min, preset_sec, start, pause,
        output min_out, sec_out, running, done
    );

    modport master (
        output tick_in, load, preset_min, preset_sec, start, pause,
        input  min_out, sec_out, running, done
    );
endinterface

// File: rtl/wash_timer.sv
// wash_timer -- MM:SS countdown driven by an external 1 Hz tick.
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : wash_timer_if.slave (commands, presets, count and status)
// Parameter MAX_MIN is the largest loadable minute value.
// Tick path: 2-flop synchronizer, then an edge register that also
// registers the one-clk tick pulse, so a second becomes visible on the
// outputs 3 clk after the first edge that samples tick_in high.
module wash_timer #(
    parameter int MAX_MIN = 99
) (
    input  logic          clk,
    input  logic          rst,
    wash_timer_if.slave   bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOADED = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_PAUSED = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [6:0] MAX_MIN_L = 7'(MAX_MIN);

    logic [2:0] state, state_nxt;
    logic [6:0] min_q, min_nxt, ld_min;
    logic [5:0] sec_q, sec_nxt, ld_sec;
    logic       done_q, done_nxt;
    logic       run_q;
    logic [1:0] sync_q;
    logic       edge_q;
    logic       tick_pulse;

    // Synchronizer and rising-edge detect; tick_pulse is registered
    // so a held-high tick_in yields exactly one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b00;
            edge_q     <= 1'b0;
            tick_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], bus.tick_in};
            edge_q     <= sync_q[1];
            tick_pulse <= sync_q[1] & ~edge_q;
        end
    end

    assign ld_min = (bus.preset_min > MAX_MIN_L) ? MAX_MIN_L : bus.preset_min;
    assign ld_sec = (bus.preset_sec > 6'd59)     ? 6'd59     : bus.preset_sec;

    always_comb begin
        state_nxt = state;
        min_nxt   = min_q;
        sec_nxt   = sec_q;
        done_nxt  = 1'b0;
        if (bus.load && state != S_RUN) begin
            min_nxt   = ld_min;
            sec_nxt   = ld_sec;
            state_nxt = (ld_min == 7'd0 && ld_sec == 6'd0) ? S_IDLE : S_LOADED;
        end else begin
            case (state)
                S_LOADED, S_PAUSED: begin
                    if (bus.start) state_nxt = S_RUN;
                end
                S_RUN: begin
                    // Guard against 00:00 so the count can never wrap.
                    if (tick_pulse && (min_q != 7'd0 || sec_q != 6'd0)) begin
                        if (sec_q != 6'd0) begin
                            sec_nxt = sec_q - 6'd1;
                        end else begin
                            min_nxt = min_q - 7'd1;
                            sec_nxt = 6'd59;
                        end
                        if (min_q == 7'd0 && sec_q == 6'd1) begin
                            state_nxt = S_DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                    // Expiry outranks a coincident pause.
                    if (state_nxt != S_DONE && bus.pause) state_nxt = S_PAUSED;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            min_q  <= 7'd0;
            sec_q  <= 6'd0;
            done_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            min_q  <= min_nxt;
            sec_q  <= sec_nxt;
            done_q <= done_nxt;
            run_q  <= (state_nxt == S_RUN);
        end
    end

    assign bus.min_out = min_q;
    assign bus.sec_out = sec_q;
    assign bus.running = run_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_wash_timer.sv
// tb_wash_timer -- directed-vector bench for wash_timer (MAX_MIN = 99).
module tb_wash_timer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   done_cnt;

    wash_timer_if bus ();

    wash_timer #(.MAX_MIN(99)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse seen on a clock edge.
    always @(posedge clk) if (bus.done === 1'b1) done_cnt = done_cnt + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int m, input int s);
        bus.load       = 1'b1;
        bus.preset_min = 7'(m);
        bus.preset_sec = 6'(s);
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_pause();
        bus.pause = 1'b1;
        step();
        bus.pause = 1'b0;
    endtask

    // Rising edge: count updates on the 4th edge after raising tick_in.
    task automatic tick_up();
        bus.tick_in = 1'b1;
        repeat (4) step();
    endtask

    task automatic tick_dn();
        bus.tick_in = 1'b0;
        repeat (3) step();
    endtask

    task automatic chk_cnt(input string tag, input int m, input int s);
        chk({tag, ".min"}, int'(bus.min_out), m);
        chk({tag, ".sec"}, int'(bus.sec_out), s);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        done_cnt       = 0;
        rst            = 1'b1;
        bus.tick_in    = 1'b0;
        bus.load       = 1'b0;
        bus.preset_min = '0;
        bus.preset_sec = '0;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        repeat (3) step();

        // reset state
        chk_cnt("rst", 0, 0);
        chk("rst.running", int'(bus.running), 0);
        chk("rst.done", int'(bus.done), 0);
        rst = 1'b0;
        step();

        // 01:02, three ticks, with latency check on the first
        do_load(1, 2);
        chk_cnt("ld0102", 1, 2);
        chk("ld0102.running", int'(bus.running), 0);
        do_start();
        chk("start.running", int'(bus.running), 1);
        bus.tick_in = 1'b1;
        repeat (3) step();
        chk_cnt("lat2clk", 1, 2);
        step();
        chk_cnt("lat3clk", 1, 1);
        tick_dn();
        tick_up(); chk_cnt("t2", 1, 0); tick_dn();
        tick_up(); chk_cnt("t3", 0, 59);
        chk("t3.running", int'(bus.running), 1);
        tick_dn();

        // expiry from 00:02
        do_pause();
        chk("pause.running", int'(bus.running), 0);
        do_load(0, 2);
        chk_cnt("ld0002", 0, 2);
        do_start();
        tick_up(); chk_cnt("e1", 0, 1);
        chk("e1.done", int'(bus.done), 0);
        tick_dn();
        tick_up(); chk_cnt("e0", 0, 0);
        chk("e0.done", int'(bus.done), 1);
        chk("e0.running", int'(bus.running), 0);
        step();
        chk("e0.done_drop", int'(bus.done), 0);
        tick_dn();
        tick_up(); chk_cnt("done_hold", 0, 0);
        chk("done_hold.done", int'(bus.done), 0);
        tick_dn();
        do_start();
        chk("done.start_ign", int'(bus.running), 0);

        // clamping, then 00:00 load returns to idle
        do_load(120, 63);
        chk_cnt("clamp", 99, 59);
        chk("clamp.running", int'(bus.running), 0);
        do_start();
        chk("clamp.start", int'(bus.running), 1);
        do_pause();
        do_load(0, 0);
        chk_cnt("ld0000", 0, 0);
        do_start();
        chk("idle.start_ign", int'(bus.running), 0);

        // pause coincident with tick pulse
        do_load(0, 10);
        do_start();
        bus.tick_in = 1'b1;
        repeat (3) step();
        bus.pause = 1'b1;
        step();
        bus.pause = 1'b0;
        chk_cnt("tickpause", 0, 9);
        chk("tickpause.running", int'(bus.running), 0);
        tick_dn();
        repeat (5) begin tick_up(); tick_dn(); end
        chk_cnt("paused_ticks", 0, 9);
        do_start();
        tick_up(); chk_cnt("resume", 0, 8);
        chk("resume.running", int'(bus.running), 1);
        tick_dn();

        // load ignored in run; start+pause together pauses
        do_load(5, 0);
        chk_cnt("run.ld_ign", 0, 8);
        chk("run.ld_ign.running", int'(bus.running), 1);
        bus.start = 1'b1;
        bus.pause = 1'b1;
        step();
        bus.start = 1'b0;
        bus.pause = 1'b0;
        chk("startpause.running", int'(bus.running), 0);

        // async reset mid-count at 00:03
        do_load(0, 3);
        do_start();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_cnt("async_rst", 0, 0);
        chk("async_rst.running", int'(bus.running), 0);
        bus.tick_in = 1'b1;
        #2 rst = 1'b0;
        repeat (5) step();
        chk("rst.no_done", done_cnt, 1);
        // tick_in still high: its one pulse was swallowed in IDLE
        do_load(0, 5);
        do_start();
        repeat (20) step();
        chk_cnt("held_after_rst", 0, 5);
        tick_dn();
        tick_up();
        repeat (20) step();
        chk_cnt("held_single", 0, 4);
        tick_dn();
        chk("done_total", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
